// File: rtl/seq_restoring_divider_if.sv
// Handshake and operand/result bundle for the sequential restoring divider.
interface seq_restoring_divider_if #(
  parameter int N = 16
);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  // Requester side: launches operations, observes results.
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  // Divider side.
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
// Working registers are kept apart from the result registers so the
// outputs only ever show completed results.
module seq_restoring_divider #(
  parameter int N = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_restoring_divider_if.slave dif
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   divisor_q;
  logic [N-1:0]   work_q;     // dividend shifting out, quotient shifting in
  logic [N-1:0]   rem_q;      // partial remainder; always < divisor, so N bits hold it
  logic [CW-1:0]  count_q;
  logic [N-1:0]   quo_out_q;
  logic [N-1:0]   rem_out_q;
  logic           dbz_q;

  logic           accept;
  logic           last_iter;
  logic [N:0]     shifted;
  logic [N:0]     trial;
  logic [N-1:0]   rem_nxt;
  logic [N-1:0]   work_nxt;

  // A new operation is taken whenever the unit is not iterating.
  assign accept    = dif.start && (state_q != RUN);
  assign last_iter = (count_q == CW'(N-1));

  // One shift-and-subtract step. The trial is N+1 bits: the shifted
  // remainder reaches 2*divisor-1, which overflows N bits for large divisors.
  always_comb begin
    shifted  = {rem_q, work_q[N-1]};
    trial    = shifted - {1'b0, divisor_q};
    rem_nxt  = shifted[N-1:0];
    work_nxt = {work_q[N-2:0], 1'b0};
    if (!trial[N]) begin
      rem_nxt  = trial[N-1:0];
      work_nxt = {work_q[N-2:0], 1'b1};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; DONE accepts a new start just like IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (dif.start) state_d = (dif.divisor == '0) ? DONE : RUN;
      RUN:  if (last_iter) state_d = DONE;
      DONE: if (dif.start) state_d = (dif.divisor == '0) ? DONE : RUN;
            else           state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, iteration, and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divisor_q <= '0;
      work_q    <= '0;
      rem_q     <= '0;
      count_q   <= '0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dbz_q     <= 1'b0;
    end else if (accept) begin
      if (dif.divisor != '0) begin
        divisor_q <= dif.divisor;
        work_q    <= dif.dividend;
        rem_q     <= '0;
        count_q   <= '0;
      end else begin
        // Divide by zero completes on the accepting edge.
        quo_out_q <= '1;
        rem_out_q <= dif.dividend;
        dbz_q     <= 1'b1;
      end
    end else if (state_q == RUN) begin
      rem_q   <= rem_nxt;
      work_q  <= work_nxt;
      count_q <= count_q + CW'(1);
      if (last_iter) begin
        quo_out_q <= work_nxt;
        rem_out_q <= rem_nxt;
        dbz_q     <= 1'b0;
      end
    end
  end

  assign dif.busy        = (state_q == RUN);
  assign dif.done        = (state_q == DONE);
  assign dif.quotient    = quo_out_q;
  assign dif.remainder   = rem_out_q;
  assign dif.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: vector table plus
// hand-written handshake/reset sequences and random operands, all results
// checked through a scoreboard queue popped on done.
module tb_seq_restoring_divider;
  localparam int N = 16;

  typedef struct {
    logic [N-1:0] a, b, q, r;
    logic         z;
  } vec_t;

  typedef struct {
    logic [N-1:0] a, b, q, r;
    logic         z;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [N-1:0] last_q = '0, last_r = '0;
  logic         last_z = 1'b0;

  seq_restoring_divider_if #(.N(N)) dif ();
  seq_restoring_divider #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .dif(dif));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pop expected results on done, otherwise outputs must hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_q = '0; last_r = '0; last_z = 1'b0;
    end else if (dif.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(dif.done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient",    32'(dif.quotient),    32'(e.q));
        chk("remainder",   32'(dif.remainder),   32'(e.r));
        chk("div_by_zero", 32'(dif.div_by_zero), 32'(e.z));
        chk("latency",     32'(cyc),             32'(e.cyc));
        if (!e.z) begin
          chk("invariant", 32'(dif.quotient) * 32'(e.b) + 32'(dif.remainder), 32'(e.a));
          chk("rem_lt_div", 32'(dif.remainder < e.b), 32'd1);
        end
      end
      last_q = dif.quotient; last_r = dif.remainder; last_z = dif.div_by_zero;
    end else begin
      chk("hold_q", 32'(dif.quotient),    32'(last_q));
      chk("hold_r", 32'(dif.remainder),   32'(last_r));
      chk("hold_z", 32'(dif.div_by_zero), 32'(last_z));
    end
  end

  // Wait for an accepting cycle, drive one start pulse, record the expectation.
  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] q, input logic [N-1:0] r, input logic z);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (dif.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("busy_timeout", 32'(dif.busy), 32'd0);
    dif.start = 1'b1; dif.dividend = a; dif.divisor = b;
    e.a = a; e.b = b; e.q = q; e.r = r; e.z = z;
    e.cyc = cyc + 1 + (z ? 0 : N);
    sb.push_back(e);
    @(negedge clk);
    dif.start = 1'b0;
  endtask

  task automatic launch_model(input logic [N-1:0] a, input logic [N-1:0] b);
    if (b == '0) launch(a, b, '1, a, 1'b1);
    else         launch(a, b, a / b, a % b, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    int busy_cnt;
    vecs = '{
      '{a:16'd1000,  b:16'd7,      q:16'd142,    r:16'd6,      z:1'b0},
      '{a:16'hFFFF,  b:16'd1,      q:16'hFFFF,   r:16'd0,      z:1'b0},
      '{a:16'd5,     b:16'd10,     q:16'd0,      r:16'd5,      z:1'b0},
      '{a:16'hFFFF,  b:16'hFFFF,   q:16'd1,      r:16'd0,      z:1'b0},
      '{a:16'hFFFF,  b:16'h8001,   q:16'd1,      r:16'h7FFE,   z:1'b0},
      '{a:16'd1234,  b:16'd0,      q:16'hFFFF,   r:16'd1234,   z:1'b1},
      '{a:16'd10,    b:16'd3,      q:16'd3,      r:16'd1,      z:1'b0},
      '{a:16'd0,     b:16'd5,      q:16'd0,      r:16'd0,      z:1'b0},
      '{a:16'd100,   b:16'd9,      q:16'd11,     r:16'd1,      z:1'b0}
    };
    dif.start = 1'b0; dif.dividend = '0; dif.divisor = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(dif.busy), 32'd0);
    chk("rst_done", 32'(dif.done), 32'd0);
    chk("rst_q",    32'(dif.quotient), 32'd0);
    chk("rst_r",    32'(dif.remainder), 32'd0);
    chk("rst_z",    32'(dif.div_by_zero), 32'd0);

    // Reset mid-operation: no done, outputs cleared, next op completes.
    launch(16'd1000, 16'd7, 16'd142, 16'd6, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(dif.busy), 32'd0);
    chk("abort_done", 32'(dif.done), 32'd0);
    chk("abort_q",    32'(dif.quotient), 32'd0);
    chk("abort_r",    32'(dif.remainder), 32'd0);

    // Basic op with busy-length count.
    launch(16'd1000, 16'd7, 16'd142, 16'd6, 1'b0);
    busy_cnt = 1; // busy already high at the first negedge after acceptance
    for (int i = 0; i < 40 && !dif.done; i++) begin
      @(negedge clk);
      if (dif.busy) busy_cnt++;
    end
    chk("busy_cycles", 32'(busy_cnt), 32'(N));
    drain();

    // Vector table; consecutive entries also exercise start in the DONE cycle.
    foreach (vecs[i]) launch(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z);
    drain();

    // start held through RUN with changing operands: only the first are used.
    @(negedge clk);
    dif.start = 1'b1; dif.dividend = 16'd200; dif.divisor = 16'd7;
    sb.push_back('{a:16'd200, b:16'd7, q:16'd28, r:16'd4, z:1'b0, cyc:cyc + 1 + N});
    for (int j = 0; j < N - 1; j++) begin
      @(negedge clk);
      dif.dividend = 16'($urandom);
      dif.divisor  = 16'($urandom);
    end
    @(negedge clk);
    dif.start = 1'b0;
    drain();

    // Random operands, biased toward zero, large and small divisors.
    for (int k = 0; k < 2000; k++) begin
      logic [N-1:0] a, b;
      int sel;
      a   = 16'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = '0;
      else if (sel == 1) b = 16'h8000 | 16'($urandom);
      else if (sel == 2) b = 16'($urandom_range(1, 15));
      else               b = 16'($urandom);
      launch_model(a, b);
    end
    drain();
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
